// File: rtl/mem_pkg.sv
// Shared state encoding and bus widths for the memory-stage SRAM controller.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } sram_state_t;

  localparam int          SRAM_ADDR_W      = 18;
  localparam int          SRAM_DATA_W      = 16;
  localparam logic [31:0] MEM_BASE_DEFAULT = 32'd1024;

endpackage

// File: rtl/sram_mem_controller.sv
// Splits a 32-bit pipeline load/store into two 16-bit SRAM half accesses,
// holding the pipeline via ready until the access has finished.
module sram_mem_controller
  import mem_pkg::*;
#(
  parameter int          ACCESS_CYCLES = 2,
  parameter logic [31:0] MEM_BASE      = MEM_BASE_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_OE_N
);

  localparam int                CNT_W    = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(ACCESS_CYCLES - 1);

  sram_state_t            state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   opWrite_q, opWrite_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [31:0]            readData_q, readData_d;
  logic [SRAM_ADDR_W-1:0] sramAddr_q, sramAddr_d;
  logic                   weN_q, weN_d;

  logic                   request;
  logic                   lastCycle;
  logic [31:0]            addrOffset;
  logic [SRAM_ADDR_W-2:0] wordIdx;
  logic                   unusedOffsetBits;

  assign request    = wr_en | rd_en;
  assign addrOffset = address - MEM_BASE;
  assign wordIdx    = addrOffset[SRAM_ADDR_W:2];
  // Byte-lane bits and the part of the offset beyond the SRAM range are dropped.
  assign unusedOffsetBits = ^{addrOffset[31:SRAM_ADDR_W+1], addrOffset[1:0]};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    opWrite_d  = opWrite_q;
    wdata_d    = wdata_q;
    readData_d = readData_q;
    sramAddr_d = sramAddr_q;
    weN_d      = weN_q;
    lastCycle  = (cnt_q == LAST_CNT);

    case (state_q)
      IDLE: begin
        if (request) begin
          state_d    = LO;
          cnt_d      = '0;
          opWrite_d  = wr_en;
          wdata_d    = write_data;
          sramAddr_d = {wordIdx, 1'b0};
          weN_d      = ~wr_en;
        end
      end
      LO: begin
        if (lastCycle) begin
          state_d    = HI;
          cnt_d      = '0;
          sramAddr_d = {sramAddr_q[SRAM_ADDR_W-1:1], 1'b1};
          if (!opWrite_q) readData_d[15:0] = SRAM_DQ;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HI: begin
        if (lastCycle) begin
          state_d = DONE;
          cnt_d   = '0;
          weN_d   = 1'b1;
          if (!opWrite_q) readData_d[31:16] = SRAM_DQ;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        // The pipeline advances on this edge, so inputs are not sampled here.
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      opWrite_q  <= 1'b0;
      wdata_q    <= '0;
      readData_q <= '0;
      sramAddr_q <= '0;
      weN_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      opWrite_q  <= opWrite_d;
      wdata_q    <= wdata_d;
      readData_q <= readData_d;
      sramAddr_q <= sramAddr_d;
      weN_q      <= weN_d;
    end
  end

  assign SRAM_DQ = (opWrite_q && state_q == LO) ? wdata_q[15:0]  :
                   (opWrite_q && state_q == HI) ? wdata_q[31:16] :
                   {SRAM_DATA_W{1'bz}};

  assign read_data = readData_q;
  assign ready     = ((state_q == IDLE) && !request) || (state_q == DONE);
  assign SRAM_ADDR = sramAddr_q;
  assign SRAM_WE_N = weN_q;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

endmodule
